// File: rtl/OoO_pkg.sv
// Shared types and sizing for the out-of-order core: decoded instruction
// record, functional-unit/op encodings and transaction-id width.
package OoO_pkg;

  localparam int NR_SB_ENTRIES = 8;
  localparam int NR_WB_PORTS   = 2;
  localparam int TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

  typedef enum logic [2:0] {
    FU_NONE,
    FU_ALU,
    FU_MULT,
    FU_LOAD,
    FU_STORE,
    FU_BRANCH
  } fu_t;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_SLL,
    OP_SRL,
    OP_MUL,
    OP_LW,
    OP_SW,
    OP_BEQ
  } fu_op;

  typedef struct packed {
    logic                     valid;
    logic [TRANS_ID_BITS-1:0] trans_id;
    fu_t                      fu;
    fu_op                     op;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic [31:0]              result;
  } decoder_t;

endpackage

// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates issued instructions in order, collects
// out-of-order writebacks and presents the head for in-order commit.
module reorder_buffer
  import OoO_pkg::*;
#(
  parameter int NR_ENTRIES  = OoO_pkg::NR_SB_ENTRIES,
  parameter int NR_WB_PORTS = OoO_pkg::NR_WB_PORTS
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        flush_i,
  input  logic                                        issue_valid_i,
  input  decoder_t                                    issue_instr_i,
  output logic                                        issue_ready_o,
  output logic [TRANS_ID_BITS-1:0]                    issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]                      wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]   wb_trans_id_i,
  input  logic [NR_WB_PORTS-1:0][31:0]                wb_result_i,
  output decoder_t                                    commit_instr_o,
  input  logic                                        commit_ack_i,
  output logic                                        empty_o
);

  localparam int PTR_W = $clog2(NR_ENTRIES);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(NR_ENTRIES);

  decoder_t                    mem_q [NR_ENTRIES];
  logic [NR_ENTRIES-1:0]       occupied_q, occupied_d;
  logic [NR_ENTRIES-1:0]       done_q, done_d;
  logic [PTR_W:0]              head_q, head_d;
  logic [PTR_W:0]              tail_q, tail_d;

  logic [PTR_W-1:0]            head_idx, tail_idx;
  logic [PTR_W:0]              count;
  logic                        alloc, pop;
  logic [NR_ENTRIES-1:0]       wb_we;
  logic [NR_ENTRIES-1:0][31:0] wb_res;

  // Pointers carry a wrap bit, so the occupancy count is their difference.
  assign head_idx = head_q[PTR_W-1:0];
  assign tail_idx = tail_q[PTR_W-1:0];
  assign count    = tail_q - head_q;

  assign issue_ready_o    = (count != FULL_COUNT);
  assign issue_trans_id_o = TRANS_ID_BITS'(tail_idx);
  assign empty_o          = (count == '0);

  always_comb begin
    commit_instr_o       = mem_q[head_idx];
    commit_instr_o.valid = occupied_q[head_idx] && done_q[head_idx];
  end

  assign alloc = issue_valid_i && issue_ready_o && !flush_i;
  assign pop   = commit_ack_i && commit_instr_o.valid && !flush_i;

  // Walking ports from highest to lowest lets the lowest index overwrite
  // any same-entry hit, giving port 0 priority.
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a path
    // that skips the assignment infers a latch.
    wb_we  = '0;
    wb_res = '0;
    for (int p = NR_WB_PORTS - 1; p >= 0; p--) begin
      if (wb_valid_i[p] && occupied_q[wb_trans_id_i[p][PTR_W-1:0]]) begin
        wb_we[wb_trans_id_i[p][PTR_W-1:0]]  = 1'b1;
        wb_res[wb_trans_id_i[p][PTR_W-1:0]] = wb_result_i[p];
      end
    end
  end

  always_comb begin
    occupied_d = occupied_q;
    done_d     = done_q | wb_we;
    head_d     = head_q;
    tail_d     = tail_q;
    if (pop) begin
      occupied_d[head_idx] = 1'b0;
      head_d               = head_q + 1'b1;
    end
    if (alloc) begin
      occupied_d[tail_idx] = 1'b1;
      done_d[tail_idx]     = 1'b0;
      tail_d               = tail_q + 1'b1;
    end
    if (flush_i) begin
      occupied_d = '0;
      done_d     = '0;
      head_d     = '0;
      tail_d     = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occupied_q <= '0;
      done_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      occupied_q <= occupied_d;
      done_q     <= done_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // NOTE: payload storage has no reset; occupied/done bits gate every use,
  // and leaving it unreset keeps it mappable to plain RAM/flops.
  always_ff @(posedge clk_i) begin
    if (alloc) begin
      mem_q[tail_idx]          <= issue_instr_i;
      mem_q[tail_idx].trans_id <= TRANS_ID_BITS'(tail_idx);
      mem_q[tail_idx].result   <= '0;
    end
    for (int e = 0; e < NR_ENTRIES; e++) begin
      if (wb_we[e]) mem_q[e].result <= wb_res[e];
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: ordering, full/wrap,
// writeback priority, flush and asynchronous reset.
module tb_reorder_buffer;
  import OoO_pkg::*;

  localparam int NP = 2;

  logic                                 clk_i = 1'b0;
  logic                                 rst_ni;
  logic                                 flush_i;
  logic                                 issue_valid_i;
  decoder_t                             issue_instr_i;
  logic                                 issue_ready_o;
  logic [TRANS_ID_BITS-1:0]             issue_trans_id_o;
  logic [NP-1:0]                        wb_valid_i;
  logic [NP-1:0][TRANS_ID_BITS-1:0]     wb_trans_id_i;
  logic [NP-1:0][31:0]                  wb_result_i;
  decoder_t                             commit_instr_o;
  logic                                 commit_ack_i;
  logic                                 empty_o;

  int n_checks = 0;
  int n_pass   = 0;

  reorder_buffer #(.NR_ENTRIES(8), .NR_WB_PORTS(NP)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .issue_valid_i    (issue_valid_i),
    .issue_instr_i    (issue_instr_i),
    .issue_ready_o    (issue_ready_o),
    .issue_trans_id_o (issue_trans_id_o),
    .wb_valid_i       (wb_valid_i),
    .wb_trans_id_i    (wb_trans_id_i),
    .wb_result_i      (wb_result_i),
    .commit_instr_o   (commit_instr_o),
    .commit_ack_i     (commit_ack_i),
    .empty_o          (empty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs;
    flush_i       = 1'b0;
    issue_valid_i = 1'b0;
    issue_instr_i = '0;
    wb_valid_i    = '0;
    wb_trans_id_i = '0;
    wb_result_i   = '0;
    commit_ack_i  = 1'b0;
  endtask

  task automatic set_issue(input logic [4:0] rd);
    issue_valid_i       = 1'b1;
    issue_instr_i       = '0;
    issue_instr_i.valid = 1'b1;
    issue_instr_i.fu    = FU_ALU;
    issue_instr_i.op    = OP_ADD;
    issue_instr_i.rd    = rd;
    issue_instr_i.rs1   = rd + 5'd1;
  endtask

  task automatic do_issue(input logic [4:0] rd);
    set_issue(rd);
    step;
    clear_inputs;
  endtask

  task automatic set_wb(input int p, input logic [2:0] id, input logic [31:0] r);
    wb_valid_i[p]    = 1'b1;
    wb_trans_id_i[p] = id;
    wb_result_i[p]   = r;
  endtask

  task automatic ack;
    commit_ack_i = 1'b1;
    step;
    clear_inputs;
  endtask

  task automatic check_head(input string tag, input logic v, input logic [4:0] rd,
                            input logic [31:0] res);
    check({tag, "_valid"}, 32'(commit_instr_o.valid), 32'(v));
    check({tag, "_rd"}, 32'(commit_instr_o.rd), 32'(rd));
    if (v) check({tag, "_result"}, commit_instr_o.result, res);
  endtask

  initial begin
    clear_inputs;
    rst_ni = 1'b0;
    #12;
    check("rst_ready", 32'(issue_ready_o), 32'd1);
    check("rst_tid", 32'(issue_trans_id_o), 32'd0);
    check("rst_valid", 32'(commit_instr_o.valid), 32'd0);
    check("rst_empty", 32'(empty_o), 32'd1);
    rst_ni = 1'b1;
    step;

    // In-order commit despite out-of-order writeback.
    do_issue(5'd1);
    do_issue(5'd2);
    do_issue(5'd3);
    check("ord_tid", 32'(issue_trans_id_o), 32'd3);
    check("ord_empty", 32'(empty_o), 32'd0);
    set_wb(0, 3'd1, 32'h22);
    step; clear_inputs;
    check("ord_head_not_done", 32'(commit_instr_o.valid), 32'd0);
    set_wb(1, 3'd0, 32'h11);
    #1;
    check("ord_no_bypass", 32'(commit_instr_o.valid), 32'd0);
    step; clear_inputs;
    check_head("ord_c0", 1'b1, 5'd1, 32'h11);
    check("ord_c0_tid", 32'(commit_instr_o.trans_id), 32'd0);
    ack;
    check_head("ord_c1", 1'b1, 5'd2, 32'h22);
    ack;
    check_head("ord_c2_held", 1'b0, 5'd3, 32'h0);
    set_wb(0, 3'd2, 32'h33);
    step; clear_inputs;
    check_head("ord_c2", 1'b1, 5'd3, 32'h33);
    ack;
    check("ord_drained", 32'(empty_o), 32'd1);

    flush_i = 1'b1;
    step; clear_inputs;
    check("flush0_tid", 32'(issue_trans_id_o), 32'd0);

    // Fill to capacity and wrap.
    for (int i = 0; i < 8; i++) do_issue(5'(10 + i));
    check("full_ready", 32'(issue_ready_o), 32'd0);
    check("full_tid", 32'(issue_trans_id_o), 32'd0);
    set_issue(5'd31);
    step; clear_inputs;
    check("full_ignored_ready", 32'(issue_ready_o), 32'd0);
    check("full_ignored_tid", 32'(issue_trans_id_o), 32'd0);
    check_head("full_head", 1'b0, 5'd10, 32'h0);
    set_wb(0, 3'd0, 32'h100);
    step; clear_inputs;
    check_head("full_head_done", 1'b1, 5'd10, 32'h100);
    set_issue(5'd31);
    commit_ack_i = 1'b1;
    step; clear_inputs;
    check("pop_only_ready", 32'(issue_ready_o), 32'd1);
    check("pop_only_tid", 32'(issue_trans_id_o), 32'd0);
    check_head("pop_only_head", 1'b0, 5'd11, 32'h0);
    do_issue(5'd20);
    check("wrap_tid", 32'(issue_trans_id_o), 32'd1);
    check("wrap_full", 32'(issue_ready_o), 32'd0);

    // Dual-port writeback: distinct ids, then same id.
    set_wb(0, 3'd1, 32'h1111);
    set_wb(1, 3'd2, 32'h2222);
    step; clear_inputs;
    set_wb(0, 3'd4, 32'hAAAA);
    set_wb(1, 3'd4, 32'hBBBB);
    step; clear_inputs;
    check_head("dual_id1", 1'b1, 5'd11, 32'h1111);
    ack;
    check_head("dual_id2", 1'b1, 5'd12, 32'h2222);
    ack;
    check_head("id3_wait", 1'b0, 5'd13, 32'h0);
    ack;
    check_head("ack_no_valid", 1'b0, 5'd13, 32'h0);
    check("ack_no_valid_tid", 32'(commit_instr_o.trans_id), 32'd3);
    set_wb(1, 3'd3, 32'h3333);
    step; clear_inputs;
    check_head("id3_done", 1'b1, 5'd13, 32'h3333);
    ack;
    check_head("same_id_prio", 1'b1, 5'd14, 32'hAAAA);
    ack;

    // Flush with five entries and concurrent activity.
    do_issue(5'd21);
    check("pre_flush_tid", 32'(issue_trans_id_o), 32'd2);
    set_wb(0, 3'd5, 32'h5555);
    step; clear_inputs;
    check_head("pre_flush_head", 1'b1, 5'd15, 32'h5555);
    flush_i = 1'b1;
    set_wb(0, 3'd6, 32'h6666);
    commit_ack_i = 1'b1;
    set_issue(5'd22);
    step; clear_inputs;
    check("flush_empty", 32'(empty_o), 32'd1);
    check("flush_valid", 32'(commit_instr_o.valid), 32'd0);
    check("flush_tid", 32'(issue_trans_id_o), 32'd0);
    check("flush_ready", 32'(issue_ready_o), 32'd1);

    // Asynchronous reset between edges.
    do_issue(5'd7);
    set_wb(0, 3'd0, 32'h77);
    step; clear_inputs;
    check_head("prerst_head", 1'b1, 5'd7, 32'h77);
    check("prerst_tid", 32'(issue_trans_id_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_ready", 32'(issue_ready_o), 32'd1);
    check("arst_tid", 32'(issue_trans_id_o), 32'd0);
    check("arst_valid", 32'(commit_instr_o.valid), 32'd0);
    check("arst_empty", 32'(empty_o), 32'd1);
    step;
    step;
    rst_ni = 1'b1;
    commit_ack_i = 1'b1;
    step; clear_inputs;
    check("postrst_valid", 32'(commit_instr_o.valid), 32'd0);
    check("postrst_empty", 32'(empty_o), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
